// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter: FSM state
// encoding and frame geometry.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 10;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port as seen by the UART transmitter. The FIFO side is master,
// the transmitter is slave.
interface fifo_uart_tx_if;

   // fifo_ready is the non-empty flag and fifo_data the head byte, valid
   // whenever fifo_ready=1; a byte is consumed on every rising clk edge where
   // fifo_rd=1, and fifo_rd is only ever raised while fifo_ready=1.
   logic       fifo_ready;
   logic [7:0] fifo_data;
   logic       fifo_rd;

   modport master (
      output fifo_ready,
      output fifo_data,
      input  fifo_rd
   );

   modport slave (
      input  fifo_ready,
      input  fifo_data,
      output fifo_rd
   );

endinterface

// File: rtl/uart_baud_cnt.sv
// Modulo-CLKS_PER_BIT bit-period counter; bit_done marks the last cycle of
// each serial bit.
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic bit_done
);

   localparam int                CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]     LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] baud_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_cnt <= '0;
      end else if (clr || (baud_cnt == LAST)) begin
         baud_cnt <= '0;
      end else begin
         baud_cnt <= baud_cnt + CW'(1);
      end
   end

   assign bit_done = (baud_cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops bytes from an upstream FIFO and sends them
// LSB-first, chaining frames with no idle gap while the FIFO stays non-empty.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   fifo_uart_tx_if.slave        fifo,
   output logic                 tx,
   output logic                 busy,
   output uart_state_e          state_dbg
);

   uart_state_e state;
   logic [7:0]  shift_reg;
   logic [2:0]  bit_cnt;
   logic        bit_done;
   logic        capture;

   // The counter is held at zero while idle so every frame starts on a fresh
   // bit period; in STOP it wraps naturally into the next start bit.
   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst      (rst),
      .clr      (state == IDLE),
      .bit_done (bit_done)
   );

   assign capture      = fifo.fifo_ready && ((state == IDLE) || ((state == STOP) && bit_done));
   assign fifo.fifo_rd = capture && !rst;
   assign busy         = (state != IDLE);
   assign state_dbg    = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         tx        <= 1'b1;
         shift_reg <= '0;
         bit_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (capture) begin
                  shift_reg <= fifo.fifo_data;
                  bit_cnt   <= '0;
                  tx        <= 1'b0;
                  state     <= START;
               end
            end
            START: begin
               if (bit_done) begin
                  tx    <= shift_reg[0];
                  state <= DATA;
               end
            end
            DATA: begin
               if (bit_done) begin
                  shift_reg <= {1'b0, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 3'd1;
                  // tx is registered, so it is loaded with the bit that
                  // becomes shift_reg[0] after this shift.
                  if (bit_cnt == 3'(DATA_BITS - 1)) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     tx <= shift_reg[1];
                  end
               end
            end
            STOP: begin
               if (bit_done) begin
                  if (capture) begin
                     shift_reg <= fifo.fifo_data;
                     bit_cnt   <= '0;
                     tx        <= 1'b0;
                     state     <= START;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4 with hand-written
// expected frame patterns.
module tb_fifo_uart_tx;
   import uart_pkg::*;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        tx;
   logic        busy;
   uart_state_e state_dbg;

   fifo_uart_tx_if fif ();

   fifo_uart_tx #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .fifo      (fif.slave),
      .tx        (tx),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Per-cycle input script and output log; index i is cycle i+1 after a pop.
   logic       rdy_s    [0:199];
   logic [7:0] dat_s    [0:199];
   logic       tx_log   [0:199];
   logic       busy_log [0:199];
   logic       rd_log   [0:199];

   // Start/data/stop bit values, index 0 is the start bit.
   localparam logic [0:9] PAT_55 = 10'b0101010101;
   localparam logic [0:9] PAT_A5 = 10'b0101001011;
   localparam logic [0:9] PAT_00 = 10'b0000000001;
   localparam logic [0:9] PAT_FF = 10'b0111111111;
   localparam logic [0:9] PAT_3C = 10'b0001111001;
   localparam logic [0:9] PAT_81 = 10'b0100000011;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_script();
      for (int i = 0; i < 200; i++) begin
         rdy_s[i] = 1'b0;
         dat_s[i] = 8'h00;
      end
   endtask

   task automatic record(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         fif.fifo_ready = rdy_s[i];
         fif.fifo_data  = dat_s[i];
         #1;
         tx_log[i]   = tx;
         busy_log[i] = busy;
         rd_log[i]   = fif.fifo_rd;
      end
   endtask

   task automatic test_reset();
      logic [0:9] pat;
      logic       e;
      pat = PAT_55;
      rst = 1'b1;
      fif.fifo_ready = 1'b1;
      fif.fifo_data  = 8'h55;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
         total++; if (fif.fifo_rd !== 1'b0) begin bad++; $display("FAIL reset_rd got=%b exp=0", fif.fifo_rd); end
         total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
      end
      rst = 1'b0;
      #1;
      total++; if (fif.fifo_rd !== 1'b1) begin bad++; $display("FAIL reset_first_pop got=%b exp=1", fif.fifo_rd); end
      clear_script();
      record(45);
      for (int j = 0; j < 45; j++) begin
         e = (j < 40) ? pat[j/CPB] : 1'b1;
         total++; if (tx_log[j] !== e) begin bad++; $display("FAIL reset_frame_tx cyc=%0d got=%b exp=%b", j+1, tx_log[j], e); end
         total++; if (busy_log[j] !== (j < 40)) begin bad++; $display("FAIL reset_frame_busy cyc=%0d got=%b", j+1, busy_log[j]); end
         total++; if (rd_log[j] !== 1'b0) begin bad++; $display("FAIL reset_frame_rd cyc=%0d got=%b exp=0", j+1, rd_log[j]); end
      end
   endtask

   task automatic test_single_byte();
      logic [0:9] pat;
      logic       e;
      pat = PAT_A5;
      fif.fifo_ready = 1'b1;
      fif.fifo_data  = 8'hA5;
      #1;
      total++; if (fif.fifo_rd !== 1'b1) begin bad++; $display("FAIL single_pop got=%b exp=1", fif.fifo_rd); end
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL single_idle_tx got=%b exp=1", tx); end
      clear_script();
      record(45);
      for (int j = 0; j < 45; j++) begin
         e = (j < 40) ? pat[j/CPB] : 1'b1;
         total++; if (tx_log[j] !== e) begin bad++; $display("FAIL single_tx cyc=%0d got=%b exp=%b", j+1, tx_log[j], e); end
         total++; if (busy_log[j] !== (j < 40)) begin bad++; $display("FAIL single_busy cyc=%0d got=%b", j+1, busy_log[j]); end
         total++; if (rd_log[j] !== 1'b0) begin bad++; $display("FAIL single_rd cyc=%0d got=%b exp=0", j+1, rd_log[j]); end
      end
   endtask

   task automatic test_back_to_back();
      logic e;
      fif.fifo_ready = 1'b1;
      fif.fifo_data  = 8'h00;
      #1;
      total++; if (fif.fifo_rd !== 1'b1) begin bad++; $display("FAIL b2b_pop0 got=%b exp=1", fif.fifo_rd); end
      clear_script();
      for (int i = 30; i < 40; i++) begin
         rdy_s[i] = 1'b1;
         dat_s[i] = 8'hFF;
      end
      record(85);
      for (int j = 0; j < 85; j++) begin
         if (j < 40)      e = PAT_00[j/CPB];
         else if (j < 80) e = PAT_FF[(j-40)/CPB];
         else             e = 1'b1;
         total++; if (tx_log[j] !== e) begin bad++; $display("FAIL b2b_tx cyc=%0d got=%b exp=%b", j, tx_log[j], e); end
         total++; if (busy_log[j] !== (j < 80)) begin bad++; $display("FAIL b2b_busy cyc=%0d got=%b", j, busy_log[j]); end
         total++; if (rd_log[j] !== (j == 39)) begin bad++; $display("FAIL b2b_rd cyc=%0d got=%b exp=%b", j, rd_log[j], (j == 39)); end
      end
   endtask

   task automatic test_empty();
      fif.fifo_ready = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         fif.fifo_data = 8'($urandom_range(0, 255));
         #1;
         total++; if (tx !== 1'b1) begin bad++; $display("FAIL empty_tx cyc=%0d got=%b exp=1", i, tx); end
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL empty_busy cyc=%0d got=%b exp=0", i, busy); end
         total++; if (fif.fifo_rd !== 1'b0) begin bad++; $display("FAIL empty_rd cyc=%0d got=%b exp=0", i, fif.fifo_rd); end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic e;
      fif.fifo_ready = 1'b1;
      fif.fifo_data  = 8'h3C;
      #1;
      total++; if (fif.fifo_rd !== 1'b1) begin bad++; $display("FAIL midrst_pop got=%b exp=1", fif.fifo_rd); end
      clear_script();
      record(16);
      for (int j = 0; j < 16; j++) begin
         e = PAT_3C[j/CPB];
         total++; if (tx_log[j] !== e) begin bad++; $display("FAIL midrst_pre_tx cyc=%0d got=%b exp=%b", j+1, tx_log[j], e); end
      end
      tick();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
      rst = 1'b1;
      #1;
      total++; if (tx !== 1'b1) begin bad++; $display("FAIL midrst_tx got=%b exp=1", tx); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL midrst_state got=%0d exp=0", state_dbg); end
      fif.fifo_ready = 1'b1;
      fif.fifo_data  = 8'h3C;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (fif.fifo_rd !== 1'b0) begin bad++; $display("FAIL midrst_rd_held got=%b exp=0", fif.fifo_rd); end
      end
      rst = 1'b0;
      #1;
      total++; if (fif.fifo_rd !== 1'b1) begin bad++; $display("FAIL midrst_repop got=%b exp=1", fif.fifo_rd); end
      clear_script();
      record(45);
      for (int j = 0; j < 45; j++) begin
         e = (j < 40) ? PAT_3C[j/CPB] : 1'b1;
         total++; if (tx_log[j] !== e) begin bad++; $display("FAIL midrst_tx_frame cyc=%0d got=%b exp=%b", j+1, tx_log[j], e); end
         total++; if (busy_log[j] !== (j < 40)) begin bad++; $display("FAIL midrst_busy_frame cyc=%0d got=%b", j+1, busy_log[j]); end
         total++; if (rd_log[j] !== 1'b0) begin bad++; $display("FAIL midrst_rd_frame cyc=%0d got=%b exp=0", j+1, rd_log[j]); end
      end
   endtask

   task automatic test_data_ignored();
      logic e;
      fif.fifo_ready = 1'b1;
      fif.fifo_data  = 8'h81;
      #1;
      total++; if (fif.fifo_rd !== 1'b1) begin bad++; $display("FAIL ignore_pop got=%b exp=1", fif.fifo_rd); end
      clear_script();
      for (int i = 0; i < 39; i++) begin
         rdy_s[i] = (i % 2 == 1);
         dat_s[i] = 8'hFF;
      end
      record(45);
      for (int j = 0; j < 45; j++) begin
         e = (j < 40) ? PAT_81[j/CPB] : 1'b1;
         total++; if (tx_log[j] !== e) begin bad++; $display("FAIL ignore_tx cyc=%0d got=%b exp=%b", j+1, tx_log[j], e); end
         total++; if (busy_log[j] !== (j < 40)) begin bad++; $display("FAIL ignore_busy cyc=%0d got=%b", j+1, busy_log[j]); end
         total++; if (rd_log[j] !== 1'b0) begin bad++; $display("FAIL ignore_rd cyc=%0d got=%b exp=0", j+1, rd_log[j]); end
      end
   endtask

   initial begin
      rst            = 1'b1;
      fif.fifo_ready = 1'b0;
      fif.fifo_data  = 8'h00;
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_empty();
      test_reset_mid_frame();
      test_data_ignored();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
